// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with framing and overrun detection.
// Define UART_RX_FIFO_EN to buffer received bytes in a FIFO_DEPTH-entry FIFO.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rx_rdy,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    // Counter runs down to zero, so loads are one less than the interval.
    localparam logic [CW-1:0] LD_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LD_HALF = CW'(H - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of 2 >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_frm_err;
    logic            r_ovr_err;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic            w_tick;
    logic            w_accept;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick   = (r_cnt == '0);
    assign w_accept = (r_state == S_STOP) && w_tick && r_rx_s;

    // Receive FSM: start detect, mid-bit sampling, stop check, break wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_frm_err <= 1'b0;
        end else begin
            r_frm_err <= 1'b0;
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_cnt   <= LD_HALF;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= LD_BIT;
                            r_bit   <= '0;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        r_cnt   <= LD_BIT;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frm_err <= 1'b1;
                            r_state   <= S_BRK;
                        end
                    end
                end
                S_BRK: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign frm_err = r_frm_err;
    assign ovr_err = r_ovr_err;

`ifdef UART_RX_FIFO_EN

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = clr_rx_rdy && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
    assign w_push  = w_accept && (!w_full || w_pop);

    // FIFO storage, pointers and occupancy; drop and flag when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovr_err <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_ovr_err <= w_accept && w_full && !w_pop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_rdy  = !w_empty;
    assign rx_data = r_mem[r_rd_ptr];

`else

    logic       r_rdy;
    logic [7:0] r_data;

    // Holding register: newest byte always wins, overwrite of an unread byte flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy     <= 1'b0;
            r_data    <= 8'h00;
            r_ovr_err <= 1'b0;
        end else begin
            r_ovr_err <= w_accept && r_rdy && !clr_rx_rdy;
            if (w_accept) begin
                r_data <= r_shift;
                r_rdy  <= 1'b1;
            end else if (clr_rx_rdy) begin
                r_rdy <= 1'b0;
            end
        end
    end

    assign rx_rdy  = r_rdy;
    assign rx_data = r_data;

`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT = 8.
// Frames are driven bit by bit on negedges; outputs sampled on negedges.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int FRAME = 10 * CPB;
    // RX falls at frame index 0, so rx_s is low at index 2 (cycle D);
    // the byte appears 77 cycles later.
    localparam int RISE_AT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rx_rdy = 1'b0;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       frm_err;
    logic       ovr_err;

    int n_vec = 0;
    int n_err = 0;

    int   g_rise;
    int   g_rise_at;
    int   g_frm;
    int   g_ovr;
    logic g_prev;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .clr_rx_rdy(clr_rx_rdy),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .frm_err   (frm_err),
        .ovr_err   (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic observe(input int k);
        if (rx_rdy && !g_prev) begin
            g_rise++;
            g_rise_at = k;
        end
        g_prev = rx_rdy;
        if (frm_err) g_frm++;
        if (ovr_err) g_ovr++;
    endtask

    task automatic clear_obs();
        g_rise    = 0;
        g_rise_at = -1;
        g_frm     = 0;
        g_ovr     = 0;
        g_prev    = rx_rdy;
    endtask

    function automatic logic line_bit(input logic [7:0] b, input logic stop, input int k);
        if (k < CPB) return 1'b0;
        if (k < 9 * CPB) return b[(k - CPB) / CPB];
        return stop;
    endfunction

    task automatic frame(input logic [7:0] b, input logic stop, input int clr_at);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            observe(k);
            RX         = line_bit(b, stop, k);
            clr_rx_rdy = (k == clr_at);
        end
    endtask

    task automatic hold(input int n, input logic lvl);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            observe(-1);
            RX         = lvl;
            clr_rx_rdy = 1'b0;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        clr_rx_rdy = 1'b1;
        @(negedge clk);
        clr_rx_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (rx_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rdy: got %b want 0", rx_rdy);
        end
        n_vec++;
        if (rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got %h want 00", rx_data);
        end
        n_vec++;
        if (frm_err !== 1'b0 || ovr_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err: got frm=%b ovr=%b want 0 0", frm_err, ovr_err);
        end
        rst = 1'b0;
        hold(10, 1'b1);
    endtask

    task automatic test_frame();
        clear_obs();
        frame(8'hA5, 1'b1, -1);
        n_vec++;
        if (g_rise_at !== RISE_AT) begin
            n_err++;
            $display("FAIL frame_latency: got %0d want %0d", g_rise_at, RISE_AT);
        end
        n_vec++;
        if (rx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL frame_data: got %h want a5", rx_data);
        end
        n_vec++;
        if (g_frm !== 0 || g_ovr !== 0) begin
            n_err++;
            $display("FAIL frame_err: got frm=%0d ovr=%0d want 0 0", g_frm, g_ovr);
        end
        ack();
        n_vec++;
        if (rx_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_clr: got rdy=%b want 0", rx_rdy);
        end
`ifndef UART_RX_FIFO_EN
        n_vec++;
        if (rx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL frame_hold: got %h want a5", rx_data);
        end
`endif
    endtask

    task automatic test_false_start();
        clear_obs();
        hold(2, 1'b0);
        hold(20, 1'b1);
        n_vec++;
        if (g_rise !== 0 || g_frm !== 0) begin
            n_err++;
            $display("FAIL glitch: got rise=%0d frm=%0d want 0 0", g_rise, g_frm);
        end
        clear_obs();
        frame(8'h5A, 1'b1, -1);
        n_vec++;
        if (g_rise_at !== RISE_AT || rx_data !== 8'h5A) begin
            n_err++;
            $display("FAIL glitch_next: got at=%0d data=%h want %0d 5a",
                     g_rise_at, rx_data, RISE_AT);
        end
    endtask

    task automatic test_framing();
        ack();
        clear_obs();
        frame(8'h3C, 1'b0, -1);
        hold(20, 1'b0);
        hold(12, 1'b1);
        n_vec++;
        if (g_frm !== 1) begin
            n_err++;
            $display("FAIL frm_pulse: got %0d pulses want 1", g_frm);
        end
        n_vec++;
        if (g_rise !== 0 || rx_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL frm_discard: got rise=%0d rdy=%b want 0 0", g_rise, rx_rdy);
        end
        clear_obs();
        frame(8'h01, 1'b1, -1);
        n_vec++;
        if (g_rise_at !== RISE_AT || rx_data !== 8'h01 || g_frm !== 0) begin
            n_err++;
            $display("FAIL frm_recover: got at=%0d data=%h frm=%0d want %0d 01 0",
                     g_rise_at, rx_data, g_frm, RISE_AT);
        end
    endtask

`ifndef UART_RX_FIFO_EN
    task automatic test_overrun();
        ack();
        clear_obs();
        frame(8'h11, 1'b1, -1);
        frame(8'h22, 1'b1, -1);
        n_vec++;
        if (g_ovr !== 1) begin
            n_err++;
            $display("FAIL ovr_pulse: got %0d pulses want 1", g_ovr);
        end
        n_vec++;
        if (rx_data !== 8'h22 || rx_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_data: got data=%h rdy=%b want 22 1", rx_data, rx_rdy);
        end
        ack();
        clear_obs();
        frame(8'h11, 1'b1, -1);
        frame(8'h22, 1'b1, RISE_AT - 1);
        n_vec++;
        if (g_ovr !== 0) begin
            n_err++;
            $display("FAIL ovr_clr_same: got %0d pulses want 0", g_ovr);
        end
        n_vec++;
        if (rx_data !== 8'h22 || rx_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_clr_data: got data=%h rdy=%b want 22 1", rx_data, rx_rdy);
        end
    endtask
`else
    task automatic test_fifo();
        logic [7:0] exp;
        ack();
        clear_obs();
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, -1);
        n_vec++;
        if (g_ovr !== 1) begin
            n_err++;
            $display("FAIL fifo_ovr: got %0d pulses want 1", g_ovr);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp = 8'(i);
            n_vec++;
            if (rx_rdy !== 1'b1 || rx_data !== exp) begin
                n_err++;
                $display("FAIL fifo_pop%0d: got rdy=%b data=%h want 1 %h",
                         i, rx_rdy, rx_data, exp);
            end
            clr_rx_rdy = 1'b1;
        end
        @(negedge clk);
        clr_rx_rdy = 1'b0;
        n_vec++;
        if (rx_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL fifo_empty: got rdy=%b want 0", rx_rdy);
        end
    endtask
`endif

    task automatic test_reset_mid();
        hold(12, 1'b1);
        frame(8'hC3, 1'b1, -1);
        clear_obs();
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            observe(k);
            if (k == 37) begin
                n_vec++;
                if (rx_rdy !== 1'b0 || rx_data !== 8'h00 ||
                    frm_err !== 1'b0 || ovr_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL mid_reset: got rdy=%b data=%h frm=%b ovr=%b want 0 00 0 0",
                             rx_rdy, rx_data, frm_err, ovr_err);
                end
            end
            RX  = line_bit(8'hF8, 1'b1, k);
            rst = (k == 36 || k == 37);
        end
        hold(12, 1'b1);
        n_vec++;
        if (g_rise !== 0 || g_frm !== 0 || rx_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_abort: got rise=%0d frm=%0d rdy=%b want 0 0 0",
                     g_rise, g_frm, rx_rdy);
        end
        clear_obs();
        frame(8'hF0, 1'b1, -1);
        n_vec++;
        if (g_rise_at !== RISE_AT || rx_data !== 8'hF0) begin
            n_err++;
            $display("FAIL mid_next: got at=%0d data=%h want %0d f0",
                     g_rise_at, rx_data, RISE_AT);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_false_start();
        test_framing();
`ifndef UART_RX_FIFO_EN
        test_overrun();
`else
        test_fifo();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
